hilo_unit: RTL and testbench
============================

HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 Parameter MULT_CYCLES, default 4, multiply latency in cycles; legal range 1..64.
REQ-002 Parameter DIV_CYCLES, default 32, divide latency in cycles; legal range 1..64.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 start  in  1  mult/div issue request, level-sampled each cycle.
REQ-006 is_div  in  1  1 = divide, 0 = multiply; sampled with start.
REQ-007 result1  in  32  ALU Result1: product low word or quotient.
REQ-008 result2  in  32  ALU Result2: product high word or remainder.
REQ-009 div_zero  in  1  divisor equals zero; sampled with start.
REQ-010 mthi, mtlo  in  1 each  write wdata to HI or LO.
REQ-011 wdata  in  32  move-to data.
REQ-012 mfhi, mflo  in  1 each  read request.
REQ-013 rdata  out  32  read data.
REQ-014 hi, lo  out  32 each  architectural HI/LO registers.
REQ-015 busy  out  1  operation in flight.
REQ-016 stall  out  1  pipeline must hold the current instruction.
REQ-017 done  out  1  one-cycle completion pulse.
REQ-018 div0_err  out  1  one-cycle divide-by-zero pulse.

Function
REQ-019 States SHALL be IDLE and BUSY; busy SHALL equal (state==BUSY), combinationally.
REQ-020 IDLE with start=1: SHALL enter BUSY, latch is_div, load 6-bit counter with (is_div ? DIV_CYCLES : MULT_CYCLES)-1.
REQ-021 BUSY with counter!=0: SHALL decrement counter by 1 each cycle.
REQ-022 BUSY with counter==0: at that edge SHALL load HI<=result2 and LO<=result1, return to IDLE, and register done=1 for exactly the next cycle.
REQ-023 busy SHALL therefore be high for exactly MULT_CYCLES or DIV_CYCLES cycles per operation; the upstream holds operands stable throughout.
REQ-024 stall SHALL equal busy & (start|mfhi|mflo|mthi|mtlo); all such requests SHALL be ignored while busy.
REQ-025 IDLE mthi/mtlo SHALL write wdata on the next edge; both asserted SHALL write both registers.
REQ-026 IDLE start with mthi/mtlo in the same cycle: the move SHALL take effect, and the completing operation SHALL later overwrite it.
REQ-027 rdata SHALL be combinational: mfhi ? hi : (mflo ? lo : 0); mfhi wins when both are asserted.
REQ-028 Same-cycle move-to and move-from of a register SHALL return the old value; no forwarding.
REQ-029 done and div0_err SHALL be low in all cycles not specified above.

Reset
REQ-030 rst=1 SHALL immediately force state IDLE, counter 0, hi=0, lo=0, done=0, div0_err=0, including mid-operation; the aborted operation SHALL NOT write HI/LO.
REQ-031 The first start after rst deasserts SHALL be accepted normally.

Configuration
REQ-032 Macro HILO_DIV0_TRAP_EN defined: IDLE start with is_div=1 and div_zero=1 SHALL NOT enter BUSY, SHALL leave HI/LO unchanged, SHALL pulse div0_err for the next cycle, and SHALL NOT pulse done.
REQ-033 Macro undefined: div_zero SHALL be ignored, div0_err SHALL be constant 0, and divide by zero SHALL run the full DIV_CYCLES and capture result1/result2 as given.

Verification
REQ-034 Multiply, defaults: start, is_div=0, result1=0x00000006, result2=0x00000001 -> busy high exactly 4 cycles, then lo=0x6 and hi=0x1, done high 1 cycle.
REQ-035 Divide: result1=0x00000003, result2=0x00000002 -> busy high exactly 32 cycles, then lo=0x3, hi=0x2; mflo asserted at cycle 10 -> stall=1 and rdata ignored until busy falls.
REQ-036 IDLE: mthi with wdata=0xDEADBEEF, then mfhi next cycle -> rdata=0xDEADBEEF; mfhi and mflo together -> rdata=hi.
REQ-037 rst pulsed at cycle 2 of a multiply -> hi=lo=0, busy=0 immediately, no done pulse.
REQ-038 With HILO_DIV0_TRAP_EN: divide with div_zero=1, hi=0x11, lo=0x22 -> div0_err pulse, busy never high, hi/lo unchanged. Without the macro: 32 busy cycles, then done.

Source files
------------

// File: rtl/hilo_unit_if.sv
// rtl/hilo_unit_if.sv - issue, move-to/from and status signals of the HI/LO unit
interface hilo_unit_if;
  logic        start;
  logic        is_div;
  logic [31:0] result1;
  logic [31:0] result2;
  logic        div_zero;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        mfhi;
  logic        mflo;
  logic [31:0] rdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;
  logic        done;
  logic        div0_err;

  modport master (
    output start, is_div, result1, result2, div_zero, mthi, mtlo, wdata, mfhi, mflo,
    input  rdata, hi, lo, busy, stall, done, div0_err
  );

  modport slave (
    input  start, is_div, result1, result2, div_zero, mthi, mtlo, wdata, mfhi, mflo,
    output rdata, hi, lo, busy, stall, done, div0_err
  );
endinterface

// File: rtl/hilo_unit.sv
// rtl/hilo_unit.sv - HI/LO register pair with multi-cycle mult/div sequencing
// Optional divide-by-zero trap enabled by defining HILO_DIV0_TRAP_EN.
module hilo_unit #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input logic       clk,
  input logic       rst,
  hilo_unit_if.slave bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES - 1);
  localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [5:0] count;
  logic [5:0] count_nxt;
  logic       complete;
  logic       trap_hit;
  logic       div_trap;
  logic       idle;

`ifdef HILO_DIV0_TRAP_EN
  assign div_trap = bus.is_div & bus.div_zero;
`else
  assign div_trap = 1'b0;
`endif

  assign idle      = (state == IDLE);
  assign bus.busy  = (state == BUSY);
  assign bus.stall = bus.busy & (bus.start | bus.mfhi | bus.mflo | bus.mthi | bus.mtlo);
  assign bus.rdata = bus.mfhi ? bus.hi : (bus.mflo ? bus.lo : 32'h0);

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    complete  = 1'b0;
    trap_hit  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (div_trap) begin
            trap_hit = 1'b1;
          end else begin
            state_nxt = BUSY;
            count_nxt = bus.is_div ? DIV_LOAD : MULT_LOAD;
          end
        end
      end
      BUSY: begin
        if (count == 6'd0) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end else begin
          count_nxt = count - 6'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Completion has priority; moves are only honoured while idle, so the
  // unit never sees both in the same edge anyway.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      count        <= 6'd0;
      bus.hi       <= 32'h0;
      bus.lo       <= 32'h0;
      bus.done     <= 1'b0;
      bus.div0_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      count        <= count_nxt;
      bus.done     <= complete;
      bus.div0_err <= trap_hit;
      if (complete) begin
        bus.hi <= bus.result2;
        bus.lo <= bus.result1;
      end else if (idle) begin
        if (bus.mthi) bus.hi <= bus.wdata;
        if (bus.mtlo) bus.lo <= bus.wdata;
      end
    end
  end

endmodule

// File: tb/tb_hilo_unit.sv
// tb/tb_hilo_unit.sv - scoreboard bench for hilo_unit
module tb_hilo_unit;
  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [63:0] sb[$];

  hilo_unit_if bus();

  hilo_unit #(.MULT_CYCLES(4), .DIV_CYCLES(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic div, input logic [31:0] r1, input logic [31:0] r2,
                        input int exp_cycles, input int probe, input logic with_mthi);
    int cycles;
    logic [63:0] exp;
    tick();
    bus.start   = 1'b1;
    bus.is_div  = div;
    bus.result1 = r1;
    bus.result2 = r2;
    if (with_mthi) begin
      bus.mthi  = 1'b1;
      bus.wdata = 32'hCAFE_F00D;
    end
    sb.push_back({r2, r1});
    tick();
    bus.start = 1'b0;
    bus.mthi  = 1'b0;
    if (with_mthi) check("start_mthi_hi", {32'h0, bus.hi}, {32'h0, 32'hCAFE_F00D});
    cycles = 0;
    while (bus.busy && cycles < 100) begin
      cycles++;
      if (cycles == probe) begin
        bus.mflo = 1'b1;
        #1 check("stall_mflo", {63'h0, bus.stall}, 64'h1);
      end
      tick();
    end
    bus.mflo = 1'b0;
    check("busy_cycles", 64'(cycles), 64'(exp_cycles));
    check("done_pulse", {63'h0, bus.done}, 64'h1);
    check("div0_err_op", {63'h0, bus.div0_err}, 64'h0);
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      check("hilo_result", {bus.hi, bus.lo}, exp);
    end else begin
      check("sb_empty", 64'h0, 64'h1);
    end
    tick();
    check("done_one_cycle", {63'h0, bus.done}, 64'h0);
  endtask

  initial begin
    logic seen_done;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.start = 0; bus.is_div = 0; bus.result1 = 0; bus.result2 = 0; bus.div_zero = 0;
    bus.mthi = 0; bus.mtlo = 0; bus.wdata = 0; bus.mfhi = 0; bus.mflo = 0;
    tick();
    tick();
    check("rst_hilo", {bus.hi, bus.lo}, 64'h0);
    check("rst_busy", {63'h0, bus.busy}, 64'h0);
    check("rst_pulses", {62'h0, bus.done, bus.div0_err}, 64'h0);
    check("rst_rdata", {32'h0, bus.rdata}, 64'h0);
    rst = 1'b0;

    // move-to / move-from while idle
    bus.mthi = 1; bus.wdata = 32'hDEAD_BEEF;
    tick();
    bus.mthi = 0; bus.mfhi = 1;
    #1 check("mfhi", {32'h0, bus.rdata}, {32'h0, 32'hDEAD_BEEF});
    bus.mfhi = 0; bus.mtlo = 1; bus.wdata = 32'h1234_5678;
    tick();
    bus.mtlo = 0; bus.mfhi = 1; bus.mflo = 1;
    #1 check("mfhi_wins", {32'h0, bus.rdata}, {32'h0, 32'hDEAD_BEEF});
    bus.mfhi = 0;
    #1 check("mflo", {32'h0, bus.rdata}, {32'h0, 32'h1234_5678});
    bus.mflo = 0;
    bus.mthi = 1; bus.mtlo = 1; bus.wdata = 32'h0BAD_CAFE; bus.mfhi = 1;
    #1 check("no_forward", {32'h0, bus.rdata}, {32'h0, 32'hDEAD_BEEF});
    tick();
    bus.mthi = 0; bus.mtlo = 0; bus.mfhi = 0;
    check("mt_both", {bus.hi, bus.lo}, {32'h0BAD_CAFE, 32'h0BAD_CAFE});

    run_op(1'b0, 32'h0000_0006, 32'h0000_0001, 4, 0, 1'b0);
    run_op(1'b1, 32'h0000_0003, 32'h0000_0002, 32, 10, 1'b0);
    run_op(1'b0, 32'h0000_0007, 32'h0000_0008, 4, 0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      run_op(1'b0, $urandom, $urandom | 32'h1, 4, 2, 1'b0);
    end

    // reset in the middle of a multiply
    tick();
    bus.start = 1; bus.is_div = 0; bus.result1 = 32'h55; bus.result2 = 32'h66;
    tick();
    bus.start = 0;
    tick();
    rst = 1'b1;
    #1 check("rst_mid_busy", {63'h0, bus.busy}, 64'h0);
    check("rst_mid_hilo", {bus.hi, bus.lo}, 64'h0);
    tick();
    rst = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.done) seen_done = 1'b1;
    end
    check("rst_no_done", {63'h0, seen_done}, 64'h0);
    check("rst_hilo_kept", {bus.hi, bus.lo}, 64'h0);
    run_op(1'b0, 32'h0000_00A5, 32'h0000_005A, 4, 0, 1'b0);

    // divide by zero
    bus.mthi = 1; bus.wdata = 32'h11;
    tick();
    bus.mthi = 0; bus.mtlo = 1; bus.wdata = 32'h22;
    tick();
    bus.mtlo = 0;
`ifdef HILO_DIV0_TRAP_EN
    bus.start = 1; bus.is_div = 1; bus.div_zero = 1;
    bus.result1 = 32'hAAAA; bus.result2 = 32'hBBBB;
    tick();
    bus.start = 0; bus.div_zero = 0;
    check("div0_busy", {63'h0, bus.busy}, 64'h0);
    check("div0_err", {63'h0, bus.div0_err}, 64'h1);
    check("div0_done", {63'h0, bus.done}, 64'h0);
    check("div0_hilo", {bus.hi, bus.lo}, {32'h11, 32'h22});
    tick();
    check("div0_err_clear", {63'h0, bus.div0_err}, 64'h0);
    check("div0_busy_after", {63'h0, bus.busy}, 64'h0);
`else
    check("div0_hilo_pre", {bus.hi, bus.lo}, {32'h11, 32'h22});
    bus.div_zero = 1;
    run_op(1'b1, 32'hAAAA, 32'hBBBB, 32, 0, 1'b0);
    bus.div_zero = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
